// File: rtl/nucleotide_stream_packer.sv
// Streaming 2-bit nucleotide packer: ASCII bases in, left-justified packed words out.
// Optional build macro LOWERCASE_BASES_EN makes a/c/g/t encode like A/C/G/T.
module nucleotide_stream_packer #(
  parameter int BASES_PER_WORD = 4,
  parameter int CNT_W          = 3,
  parameter int TOT_W          = 32
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [7:0]                  In_data,
  input  logic                        In_valid,
  input  logic                        In_last,
  output logic                        In_ready,
  output logic [2*BASES_PER_WORD-1:0] Out_data,
  output logic [CNT_W-1:0]            Out_count,
  output logic                        Out_last,
  output logic                        Out_err,
  output logic                        Out_valid,
  input  logic                        Out_ready,
  output logic [TOT_W-1:0]            Base_total
);

  localparam int N = BASES_PER_WORD;
  localparam int W = 2 * BASES_PER_WORD;
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(N - 1);

  logic [W-1:0]     acc_reg;
  logic [CNT_W-1:0] fill_reg;
  logic             acc_err_reg;
  logic [W-1:0]     data_reg;
  logic [CNT_W-1:0] count_reg;
  logic             last_reg;
  logic             err_reg;
  logic             valid_reg;
  logic [TOT_W-1:0] total_reg;

  logic [1:0]   code;
  logic         code_err;
  logic         accept;
  logic         complete;
  logic [W-1:0] shifted;
  logic [W-1:0] justified;

  always_comb begin
    code     = 2'b00;
    code_err = 1'b0;
    case (In_data)
      8'h41: code = 2'b00;
      8'h43: code = 2'b01;
      8'h47: code = 2'b10;
      8'h54: code = 2'b11;
`ifdef LOWERCASE_BASES_EN
      8'h61: code = 2'b00;
      8'h63: code = 2'b01;
      8'h67: code = 2'b10;
      8'h74: code = 2'b11;
`endif
      default: code_err = 1'b1;
    endcase
  end

  assign In_ready = !valid_reg || Out_ready;
  assign accept   = In_valid && In_ready;
  assign complete = accept && ((fill_reg == LAST_FILL) || In_last);
  assign shifted  = {acc_reg[W-3:0], code};

  // Upper pairs of the accumulator are always zero, so shifting left pads the tail with 00.
  always_comb begin
    justified = shifted << (2 * (N - 1 - int'(fill_reg)));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_reg     <= '0;
      fill_reg    <= '0;
      acc_err_reg <= 1'b0;
      data_reg    <= '0;
      count_reg   <= '0;
      last_reg    <= 1'b0;
      err_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      total_reg   <= '0;
    end else begin
      if (accept) begin
        if (complete) begin
          acc_reg     <= '0;
          fill_reg    <= '0;
          acc_err_reg <= 1'b0;
        end else begin
          acc_reg     <= shifted;
          fill_reg    <= fill_reg + CNT_W'(1);
          acc_err_reg <= acc_err_reg | code_err;
        end
        if (total_reg != '1) begin
          total_reg <= total_reg + TOT_W'(1);
        end
      end
      // A completing word reloads the output even when the previous one is leaving this edge.
      if (complete) begin
        data_reg  <= justified;
        count_reg <= fill_reg + CNT_W'(1);
        last_reg  <= In_last;
        err_reg   <= acc_err_reg | code_err;
        valid_reg <= 1'b1;
      end else if (valid_reg && Out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign Out_data   = data_reg;
  assign Out_count  = count_reg;
  assign Out_last   = last_reg;
  assign Out_err    = err_reg;
  assign Out_valid  = valid_reg;
  assign Base_total = total_reg;

endmodule

// File: tb/tb_nucleotide_stream_packer.sv
// Directed and randomized checks of nucleotide_stream_packer against a word-level reference model.
module tb_nucleotide_stream_packer;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int TOT_W = 4;
  localparam int W     = 2 * N;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b1;
  logic [7:0]       In_data = 8'h00;
  logic             In_valid = 1'b0;
  logic             In_last = 1'b0;
  logic             In_ready;
  logic [W-1:0]     Out_data;
  logic [CNT_W-1:0] Out_count;
  logic             Out_last;
  logic             Out_err;
  logic             Out_valid;
  logic             Out_ready = 1'b0;
  logic [TOT_W-1:0] Base_total;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_bp = 1'b0;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             err;
  } word_t;

  word_t      got_q[$];
  word_t      exp_q[$];
  logic [7:0] pend[$];
  int         total = 0;

  nucleotide_stream_packer #(
    .BASES_PER_WORD(N),
    .CNT_W(CNT_W),
    .TOT_W(TOT_W)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .In_data(In_data),
    .In_valid(In_valid),
    .In_last(In_last),
    .In_ready(In_ready),
    .Out_data(Out_data),
    .Out_count(Out_count),
    .Out_last(Out_last),
    .Out_err(Out_err),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Base_total(Base_total)
  );

  always #5 Clk = ~Clk;

  // A word seen valid+ready at the falling edge transfers on the next rising edge.
  always @(negedge Clk) begin
    if (Rst_n && Out_valid && Out_ready) begin
      word_t w;
      w = {Out_data, Out_count, Out_last, Out_err};
      got_q.push_back(w);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void enc(input logic [7:0] b, output int c, output bit e);
    e = 1'b0;
    c = 0;
    case (b)
      "A": c = 0;
      "C": c = 1;
      "G": c = 2;
      "T": c = 3;
`ifdef LOWERCASE_BASES_EN
      "a": c = 0;
      "c": c = 1;
      "g": c = 2;
      "t": c = 3;
`endif
      default: e = 1'b1;
    endcase
  endfunction

  function automatic void model_push(input logic [7:0] b, input bit last);
    pend.push_back(b);
    total++;
    if (pend.size() == N || last) begin
      word_t w;
      int    v;
      int    c;
      bit    e;
      bit    ce;
      v = 0;
      e = 1'b0;
      for (int i = 0; i < pend.size(); i++) begin
        enc(pend[i], c, ce);
        v = v + c * (4 ** (N - 1 - i));
        e = e | ce;
      end
      w.data  = W'(v);
      w.count = CNT_W'(pend.size());
      w.last  = last;
      w.err   = e;
      exp_q.push_back(w);
      pend.delete();
    end
  endfunction

  function automatic int exp_total();
    int lim;
    lim = (1 << TOT_W) - 1;
    return (total > lim) ? lim : total;
  endfunction

  task automatic send(input logic [7:0] b, input bit last);
    bit done;
    done = 1'b0;
    In_data  = b;
    In_valid = 1'b1;
    In_last  = last;
    for (int k = 0; k < 200 && !done; k++) begin
      if (rand_bp) Out_ready = ($urandom_range(0, 9) < 7);
      @(negedge Clk);
      done = In_ready;
      @(posedge Clk);
      #1;
    end
    In_valid = 1'b0;
    In_last  = 1'b0;
    check("accept_timeout", 32'(done), 32'd1);
    if (done) model_push(b, last);
  endtask

  task automatic send_str(input string s, input bit last_on_end);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], last_on_end && (i == s.len() - 1));
    end
  endtask

  task automatic do_reset();
    #2 Rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(Out_valid), 32'd0);
    check("rst_data", 32'(Out_data), 32'd0);
    check("rst_count", 32'(Out_count), 32'd0);
    check("rst_last_err", {30'd0, Out_last, Out_err}, 32'd0);
    check("rst_total", 32'(Base_total), 32'd0);
    check("rst_ready", 32'(In_ready), 32'd1);
    pend.delete();
    exp_q.delete();
    got_q.delete();
    total = 0;
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string tag);
    rand_bp   = 1'b0;
    Out_ready = 1'b1;
    for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) @(posedge Clk);
    repeat (2) @(posedge Clk);
    #1;
    check({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_total"}, 32'(Base_total), 32'(exp_total()));
  endtask

  logic [7:0] tbl [10];

  initial begin
    tbl = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74, 8'h58, 8'h4E};
    do_reset();

    // Full word, latency one cycle after the 4th accept.
    Out_ready = 1'b1;
    send_str("ACG", 1'b0);
    check("acgt_early_valid", 32'(Out_valid), 32'd0);
    send("T", 1'b0);
    check("acgt_valid", 32'(Out_valid), 32'd1);
    check("acgt_data", 32'(Out_data), 32'h1B);
    check("acgt_count", 32'(Out_count), 32'd4);
    check("acgt_last_err", {30'd0, Out_last, Out_err}, 32'd0);
    drain("acgt");

    // Partial flush; a lone In_last without In_valid must be ignored.
    send_str("GA", 1'b0);
    In_last = 1'b1;
    @(posedge Clk);
    #1 In_last = 1'b0;
    send("C", 1'b1);
    check("flush_data", 32'(Out_data), 32'h84);
    check("flush_count", 32'(Out_count), 32'd3);
    check("flush_last", 32'(Out_last), 32'd1);
    send_str("ACGT", 1'b0);
    check("after_flush_data", 32'(Out_data), 32'h1B);
    drain("flush");

    // Error word followed by a clean one.
    do_reset();
    Out_ready = 1'b1;
    send_str("AXGT", 1'b0);
    check("err_data", 32'(Out_data), 32'h0B);
    check("err_flag", 32'(Out_err), 32'd1);
    send_str("TTTT", 1'b0);
    check("clean_data", 32'(Out_data), 32'hFF);
    check("clean_flag", 32'(Out_err), 32'd0);
    drain("err");

    // Backpressure: word held stable for 10 cycles, no data loss.
    do_reset();
    Out_ready = 1'b0;
    send_str("ACGT", 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    check("stall_valid", 32'(Out_valid), 32'd1);
    check("stall_data", 32'(Out_data), 32'h1B);
    check("stall_ready", 32'(In_ready), 32'd0);
    fork
      begin
        repeat (7) @(posedge Clk);
        #1 Out_ready = 1'b1;
      end
    join_none
    send_str("ACGT", 1'b0);
    drain("stall");
    check("stall_total", 32'(Base_total), 32'd8);

    // Reset while a word is held, then mid-word.
    Out_ready = 1'b0;
    send_str("ACGT", 1'b0);
    check("held_before_rst", 32'(Out_valid), 32'd1);
    do_reset();
    Out_ready = 1'b1;
    send_str("AC", 1'b0);
    do_reset();
    send_str("GTAC", 1'b0);
    check("post_rst_data", 32'(Out_data), 32'hB1);
    drain("rst");

    // Lowercase handling depends on the build.
    send_str("acgt", 1'b0);
`ifdef LOWERCASE_BASES_EN
    check("lower_data", 32'(Out_data), 32'h1B);
    check("lower_err", 32'(Out_err), 32'd0);
`else
    check("lower_data", 32'(Out_data), 32'h00);
    check("lower_err", 32'(Out_err), 32'd1);
`endif
    drain("lower");

    // Randomized traffic with backpressure; Base_total saturates at 15.
    do_reset();
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(tbl[$urandom_range(0, 9)], ($urandom_range(0, 7) == 0) || (i == 299));
      if ($urandom_range(0, 3) == 0) begin
        Out_ready = ($urandom_range(0, 1) == 1);
        @(posedge Clk);
        #1;
      end
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
